booth_mult_seq: RTL and testbench

- Iterative radix-2 Booth multiplier, parametrised in operand width.
- Owns its A/Q/Q-1 register set, iteration counter and start/done handshake; one Booth step per clock.
- Sits beside the ALU as the multi-cycle multiply unit.
- The controller issues a start pulse and waits for done.

---
 rtl/booth_mult_seq.sv | 148 ++++++++++++++
 tb/tb_booth_mult_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth multiplier: one Booth step per clock, 2*WIDTH-bit product.
// Latency: done pulses N cycles after the accepted start edge (N=WIDTH, or WIDTH+1 with BOOTH_UNSIGNED_MODE_EN).
// Backpressure: none; start is ignored while busy, and product holds until the next operation completes.
//
// Ports:
//    clk, rst_n      rising-edge clock, asynchronous active-low reset
//    start           request pulse; operands are sampled on the same edge (IDLE or DONE only)
//    op_signed       present only with BOOTH_UNSIGNED_MODE_EN: 1 = signed, 0 = unsigned operands
//    multiplicand    M operand
//    multiplier      Q operand
//    busy            high while iterating
//    done            one-cycle pulse; product valid
//    product         registered result
//
// Optional feature macro: BOOTH_UNSIGNED_MODE_EN (adds op_signed and unsigned support).
module booth_mult_seq #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
`ifdef BOOTH_UNSIGNED_MODE_EN
   input  logic               op_signed,
`endif
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

`ifdef BOOTH_UNSIGNED_MODE_EN
   // Operands are widened by one bit so an unsigned value becomes a positive
   // signed value; the extra Booth step handles that extra bit.
   localparam int QW = WIDTH + 1;
   localparam int AW = WIDTH + 2;
   localparam int N  = WIDTH + 1;
`else
   localparam int QW = WIDTH;
   localparam int AW = WIDTH + 1;
   localparam int N  = WIDTH;
`endif
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] m_reg;
   logic [AW-1:0] a_reg;
   logic [QW-1:0] q_reg;
   logic          q1_reg;
   logic [CW-1:0] cnt;

   logic          last;
   logic          load;
   logic          m_ext;
   logic [AW-1:0] m_load;
   logic [QW-1:0] q_load;
   logic [AW-1:0] a_sum;
   logic [AW-1:0] a_nxt;
   logic [QW-1:0] q_nxt;
   logic          q1_nxt;

   assign last = (cnt == CW'(N - 1));
   assign load = start && (state != CALC);
   assign busy = (state == CALC);
   assign done = (state == DONE);

   // Operand extension into the A-width domain (A is one bit wider than the
   // operand so A-M cannot overflow for the most negative M).
   always_comb begin
      m_ext = multiplicand[WIDTH-1];
`ifdef BOOTH_UNSIGNED_MODE_EN
      m_ext  = op_signed & multiplicand[WIDTH-1];
      q_load = {op_signed & multiplier[WIDTH-1], multiplier};
`else
      q_load = multiplier;
`endif
      m_load = {{(AW - WIDTH){m_ext}}, multiplicand};
   end

   // One Booth step: conditional add/sub, then arithmetic shift of {A,Q,Q-1}.
   always_comb begin
      a_sum = a_reg;
      case ({q_reg[0], q1_reg})
         2'b01:   a_sum = a_reg + m_reg;
         2'b10:   a_sum = a_reg - m_reg;
         default: a_sum = a_reg;
      endcase
      a_nxt  = {a_sum[AW-1], a_sum[AW-1:1]};
      q_nxt  = {a_sum[0], q_reg[QW-1:1]};
      q1_nxt = q_reg[0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CALC;
         CALC:    if (last)  state_nxt = DONE;
         DONE:    state_nxt = start ? CALC : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_reg   <= '0;
         a_reg   <= '0;
         q_reg   <= '0;
         q1_reg  <= 1'b0;
         cnt     <= '0;
         product <= '0;
      end else if (load) begin
         m_reg  <= m_load;
         a_reg  <= '0;
         q_reg  <= q_load;
         q1_reg <= 1'b0;
         cnt    <= '0;
      end else if (state == CALC) begin
         a_reg  <= a_nxt;
         q_reg  <= q_nxt;
         q1_reg <= q1_nxt;
         // Counter holds on the final step rather than wrapping.
         if (!last) begin
            cnt <= cnt + 1'b1;
         end else begin
`ifdef BOOTH_UNSIGNED_MODE_EN
            product <= {a_nxt[WIDTH-2:0], q_nxt};
`else
            product <= {a_nxt[WIDTH-1:0], q_nxt};
`endif
         end
      end
   end

endmodule

// File: tb/tb_booth_mult_seq.sv
module tb_booth_mult_seq;

   localparam int W = 8;
`ifdef BOOTH_UNSIGNED_MODE_EN
   localparam int N = W + 1;
`else
   localparam int N = W;
`endif

   logic           clk;
   logic           rst_n;
   logic           start;
   logic           op_signed;
   logic [W-1:0]   multiplicand;
   logic [W-1:0]   multiplier;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;

   int total = 0;
   int bad   = 0;

   logic [2*W-1:0] exp_q[$];

   booth_mult_seq #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
`ifdef BOOTH_UNSIGNED_MODE_EN
      .op_signed    (op_signed),
`endif
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: every done pulse pops the oldest expected product.
   always @(negedge clk) begin
      if (rst_n && done) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL product_unexpected: got 0x%0h with no expected entry", product);
         end else begin
            logic [2*W-1:0] e;
            e = exp_q.pop_front();
            if (product !== e) begin
               bad++;
               $display("FAIL product: got 0x%0h expected 0x%0h", product, e);
            end
         end
      end
   end

   // Issue one operation, optionally inject a second start at CALC cycle
   // inj_cyc, and check done latency and busy duration.
   task automatic run_op(input string name, input logic [W-1:0] m, input logic [W-1:0] q,
                         input logic sgn, input logic [2*W-1:0] exp, input int inj_cyc);
      int busy_cnt;
      int done_cyc;
      busy_cnt = 0;
      done_cyc = 0;
      @(negedge clk);
      start = 1'b1; multiplicand = m; multiplier = q; op_signed = sgn;
      exp_q.push_back(exp);
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= N + 4; c++) begin
         @(negedge clk);
         if (c == inj_cyc) begin
            start = 1'b1; multiplicand = 8'd1; multiplier = 8'd1;
         end else begin
            start = 1'b0;
         end
         if (busy) busy_cnt++;
         if (done) begin
            done_cyc = c;
            break;
         end
      end
      start = 1'b0;
      check({name, "_done_latency"}, done_cyc, N + 1);
      check({name, "_busy_cycles"}, busy_cnt, N);
   endtask

   initial begin
      int d1;
      int d2;
      start = 1'b0; multiplicand = '0; multiplier = '0; op_signed = 1'b1;
      rst_n = 1'b0;
      #12;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_product", product, 0);
      @(negedge clk) rst_n = 1'b1;

      run_op("m3_qm5", 8'd3, 8'hFB, 1'b1, 16'hFFF1, 0);
      run_op("m128_q128", 8'h80, 8'h80, 1'b1, 16'h4000, 0);
      run_op("m128_q127", 8'h80, 8'h7F, 1'b1, 16'hC080, 0);
      run_op("mid_start", 8'd7, 8'd6, 1'b1, 16'h002A, 3);
      check("product_held", product, 16'h002A);

      // Asynchronous reset in the middle of an operation (not scoreboarded).
      @(negedge clk);
      start = 1'b1; multiplicand = 8'd9; multiplier = 8'd9;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_busy", busy, 0);
      check("async_rst_done", done, 0);
      check("async_rst_product", product, 0);
      @(negedge clk) rst_n = 1'b1;
      run_op("after_rst", 8'd2, 8'd2, 1'b1, 16'h0004, 0);

      // Back-to-back: start held through the first done cycle.
      d1 = 0; d2 = 0;
      @(negedge clk);
      start = 1'b1; multiplicand = 8'd5; multiplier = 8'd5;
      exp_q.push_back(16'h0019);
      exp_q.push_back(16'h0001);
      @(posedge clk);
      #1 multiplicand = 8'hFF; multiplier = 8'hFF;
      for (int c = 1; c <= 3 * N + 6; c++) begin
         @(negedge clk);
         if (d1 != 0) start = 1'b0;
         if (done) begin
            if (d1 == 0) d1 = c;
            else begin
               d2 = c;
               break;
            end
         end
      end
      start = 1'b0;
      check("b2b_first_done", d1, N + 1);
      check("b2b_spacing", d2 - d1, N + 1);

`ifdef BOOTH_UNSIGNED_MODE_EN
      run_op("unsigned_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 0);
      run_op("signed_ff", 8'hFF, 8'hFF, 1'b1, 16'h0001, 0);
`endif

      repeat (3) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
